// File: rtl/rijndael_pkg.sv
// Shared constants and helpers for the iterative Rijndael SubBytes datapath.
// Used by rijndael_sbox and rijndael_subbytes_iter.
package rijndael_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDone} sb_state_e;

    // Forward S-box, indexed by the input byte.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // ShiftRows left-rotation (in columns) for a given row and block width.
    function automatic int unsigned shift_offset(input int unsigned nb, input int unsigned row);
        int unsigned off;
        off = row;
        if (row == 2 && nb == 8) off = 3;
        if (row == 3 && nb >= 7) off = 4;
        return off;
    endfunction

    // MSB bit index of byte (col,row); byte 0 sits at the top of the vector.
    function automatic int unsigned byte_hi(input int unsigned nb, input int unsigned col,
                                            input int unsigned row);
        return 32 * nb - 1 - 8 * (4 * col + row);
    endfunction

endpackage

// File: rtl/rijndael_sbox.sv
// Single combinational forward S-box lookup.
module rijndael_sbox
    import rijndael_pkg::*;
(
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    assign data_o = SBOX[data_i];

endmodule

// File: rtl/rijndael_subbytes_iter.sv
// Iterative SubBytes stage: substitutes LANES bytes per cycle through shared S-boxes and
// presents the full state over valid/ready.
// Build option: RIJNDAEL_SUBBYTES_SHIFTROWS_EN folds ShiftRows into the output mux.
module rijndael_subbytes_iter
    import rijndael_pkg::*;
#(
    parameter int unsigned NB    = 4,
    parameter int unsigned LANES = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [32*NB-1:0] state_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [32*NB-1:0] state_o,
    output logic            busy_o
);

    localparam int unsigned NBytes = 4 * NB;
    localparam int unsigned CW     = $clog2(NBytes);
    localparam logic [CW-1:0] LastCnt = CW'(NBytes - LANES);

    if (NB < 4 || NB > 8) begin : g_bad_nb
        $error("NB must be in 4..8");
    end
    if ((NBytes % LANES) != 0) begin : g_bad_lanes
        $error("LANES must divide 4*NB");
    end

    sb_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [32*NB-1:0]  work_q, work_d;
    int unsigned       lane_hi [LANES];
    logic [7:0]        sbox_in [LANES];
    logic [7:0]        sbox_out [LANES];

    // Select the current byte group feeding the shared S-boxes.
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_hi[l] = byte_hi(NB, (32'(cnt_q) + l) / 4, (32'(cnt_q) + l) % 4);
            sbox_in[l] = work_q[lane_hi[l] -: 8];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        rijndael_sbox u_sbox (
            .data_i(sbox_in[g]),
            .data_o(sbox_out[g])
        );
    end

    // FSM next state, counter advance and working-register write-back.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        unique case (state_q)
            StIdle: begin
                if (valid_i) begin
                    work_d  = state_i;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    work_d[lane_hi[l] -: 8] = sbox_out[l];
                end
                // Counter saturates at the last group rather than wrapping.
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CW'(LANES);
                end
            end
            StDone: begin
                if (ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register; reset aborts any block in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

    // Handshake flags depend on the FSM only.
    always_comb begin
        ready_o = (state_q == StIdle);
        valid_o = (state_q == StDone);
        busy_o  = (state_q != StIdle);
    end

    // Output mux: zero unless presenting, optionally row-rotated.
    always_comb begin
        state_o = '0;
        if (state_q == StDone) begin
`ifdef RIJNDAEL_SUBBYTES_SHIFTROWS_EN
            for (int unsigned c = 0; c < NB; c++) begin
                for (int unsigned r = 0; r < 4; r++) begin
                    state_o[byte_hi(NB, c, r) -: 8] =
                        work_q[byte_hi(NB, (c + shift_offset(NB, r)) % NB, r) -: 8];
                end
            end
`else
            state_o = work_q;
`endif
        end
    end

endmodule
